// File: rtl/irq_controller_if.sv
// irq_controller_if: core-side trap/ack signals plus peripheral request lines of the interrupt arbiter.
interface irq_controller_if #(parameter int N_IRQ = 16);
  logic             exception_i;
  logic             mret_i;
  logic             stall_i;
  logic [N_IRQ-1:0] irq_req_i;
  logic [31:0]      mie_i;
  logic             irq_o;
  logic [31:0]      irq_cause_o;
  logic [N_IRQ-1:0] irq_ret_o;
  modport master (output exception_i, mret_i, stall_i, irq_req_i, mie_i,
                  input  irq_o, irq_cause_o, irq_ret_o);
  modport slave  (input  exception_i, mret_i, stall_i, irq_req_i, mie_i,
                  output irq_o, irq_cause_o, irq_ret_o);
endinterface

// File: rtl/irq_controller.sv
// irq_controller: masks and prioritises IRQ lines, issues one-cycle traps, tracks nesting, acks on mret.
module irq_controller #(
  parameter int N_IRQ      = 16,
  parameter int CAUSE_BASE = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  irq_controller_if.slave  bus
);
  localparam int IW = N_IRQ > 1 ? $clog2(N_IRQ) : 1;
  logic [N_IRQ-1:0] enabled;
  logic [N_IRQ-1:0] ret;
  logic [IW-1:0]    winner;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    sel;
  logic             irq_h;
  logic             exc_h;
  logic             take;
  assign enabled = bus.irq_req_i & bus.mie_i[CAUSE_BASE +: N_IRQ];
  always_comb begin
    winner = '0;
    for (int k = N_IRQ - 1; k >= 0; k--)
      if (enabled[k]) winner = IW'(k);
  end
  // The ack cycle also blocks a take so a re-raised line lands one cycle after the pulse.
  assign take = |enabled & ~irq_h & ~exc_h & ~bus.exception_i & ~bus.stall_i & ~|ret & ~rst_i;
  assign sel  = take ? winner : idx;
  assign bus.irq_o       = take;
  assign bus.irq_cause_o = (take | irq_h) ? {1'b1, 26'b0, 5'(CAUSE_BASE + int'(sel))} : 32'h0;
  assign bus.irq_ret_o   = ret;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_h <= 1'b0;
      exc_h <= 1'b0;
      idx   <= '0;
      ret   <= '0;
    end else begin
      ret <= '0;
      if (take) begin
        irq_h <= 1'b1;
        idx   <= winner;
      end
      if (bus.exception_i) exc_h <= 1'b1;
      else if (bus.mret_i) begin
        if (exc_h) exc_h <= 1'b0;
        else if (irq_h) begin
          irq_h <= 1'b0;
          ret   <= N_IRQ'(1) << idx;
        end
      end
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scenario tasks with hand-computed expectations for irq_controller.
module tb_irq_controller;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int checks = 0;
  int errors = 0;
  irq_controller_if #(.N_IRQ(16)) bus ();
  irq_controller #(.N_IRQ(16), .CAUSE_BASE(16)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask
  task automatic do_mret();
    bus.mret_i = 1'b1;
    tick();
    bus.mret_i = 1'b0;
  endtask
  task automatic test_reset();
    bus.exception_i = 0; bus.mret_i = 0; bus.stall_i = 0; bus.irq_req_i = 0; bus.mie_i = 0;
    rst_i = 1'b1;
    tick();
    tick();
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", bus.irq_o); end
    checks++; if (bus.irq_cause_o !== 32'h0) begin errors++; $display("FAIL reset_cause got %h exp 0", bus.irq_cause_o); end
    checks++; if (bus.irq_ret_o !== 16'h0) begin errors++; $display("FAIL reset_ret got %h exp 0", bus.irq_ret_o); end
    rst_i = 1'b0;
    tick();
  endtask
  task automatic test_priority();
    bus.mie_i = 32'hFFFF_0000; bus.irq_req_i = 16'h0006;
    #1;
    checks++; if (bus.irq_o !== 1'b1) begin errors++; $display("FAIL prio_take got %b exp 1", bus.irq_o); end
    checks++; if (bus.irq_cause_o !== 32'h8000_0011) begin errors++; $display("FAIL prio_cause got %h exp 80000011", bus.irq_cause_o); end
    tick();
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL prio_one_cycle got %b exp 0", bus.irq_o); end
    checks++; if (bus.irq_cause_o !== 32'h8000_0011) begin errors++; $display("FAIL prio_inservice got %h exp 80000011", bus.irq_cause_o); end
    bus.mie_i = 32'h0;
    #1;
    checks++; if (bus.irq_cause_o !== 32'h8000_0011) begin errors++; $display("FAIL prio_mie_change got %h exp 80000011", bus.irq_cause_o); end
    bus.mie_i = 32'hFFFF_0000;
    do_mret();
    bus.irq_req_i = 16'h0004;
    #1;
    checks++; if (bus.irq_ret_o !== 16'h0002) begin errors++; $display("FAIL prio_ack got %h exp 0002", bus.irq_ret_o); end
    bus.irq_req_i = 16'h0;
    tick();
    checks++; if (bus.irq_ret_o !== 16'h0) begin errors++; $display("FAIL prio_ack_pulse got %h exp 0000", bus.irq_ret_o); end
    checks++; if (bus.irq_cause_o !== 32'h0) begin errors++; $display("FAIL prio_idle_cause got %h exp 0", bus.irq_cause_o); end
  endtask
  task automatic test_masking();
    int bad = 0;
    bus.irq_req_i = 16'h0001; bus.mie_i = 32'h0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.irq_o !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mask_hold got %0d takes exp 0", bad); end
    bus.mie_i = 32'h0001_0000;
    #1;
    checks++; if (bus.irq_o !== 1'b1) begin errors++; $display("FAIL mask_take got %b exp 1", bus.irq_o); end
    checks++; if (bus.irq_cause_o !== 32'h8000_0010) begin errors++; $display("FAIL mask_cause got %h exp 80000010", bus.irq_cause_o); end
    tick();
    do_mret();
    bus.irq_req_i = 16'h0;
    #1;
    checks++; if (bus.irq_ret_o !== 16'h0001) begin errors++; $display("FAIL mask_ack got %h exp 0001", bus.irq_ret_o); end
    tick();
  endtask
  task automatic test_block();
    bus.mie_i = 32'hFFFF_0000; bus.irq_req_i = 16'h0004; bus.stall_i = 1'b1;
    #1;
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL block_stall got %b exp 0", bus.irq_o); end
    tick();
    bus.stall_i = 1'b0; bus.exception_i = 1'b1;
    #1;
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL block_exc got %b exp 0", bus.irq_o); end
    tick();
    bus.exception_i = 1'b0; bus.mret_i = 1'b1;
    #1;
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL block_exc_h got %b exp 0", bus.irq_o); end
    tick();
    bus.mret_i = 1'b0;
    #1;
    checks++; if (bus.irq_ret_o !== 16'h0) begin errors++; $display("FAIL block_no_ack got %h exp 0000", bus.irq_ret_o); end
    checks++; if (bus.irq_o !== 1'b1) begin errors++; $display("FAIL block_take got %b exp 1", bus.irq_o); end
    checks++; if (bus.irq_cause_o !== 32'h8000_0012) begin errors++; $display("FAIL block_cause got %h exp 80000012", bus.irq_cause_o); end
    tick();
    do_mret();
    bus.irq_req_i = 16'h0;
    #1;
    checks++; if (bus.irq_ret_o !== 16'h0004) begin errors++; $display("FAIL block_ack got %h exp 0004", bus.irq_ret_o); end
    tick();
  endtask
  task automatic test_nesting();
    bus.irq_req_i = 16'h0008;
    #1;
    checks++; if (bus.irq_cause_o !== 32'h8000_0013) begin errors++; $display("FAIL nest_cause got %h exp 80000013", bus.irq_cause_o); end
    tick();
    bus.exception_i = 1'b1; bus.mret_i = 1'b1;
    tick();
    bus.exception_i = 1'b0;
    #1;
    checks++; if (bus.irq_ret_o !== 16'h0) begin errors++; $display("FAIL nest_exc_mret got %h exp 0000", bus.irq_ret_o); end
    tick();
    bus.mret_i = 1'b0;
    #1;
    checks++; if (bus.irq_ret_o !== 16'h0) begin errors++; $display("FAIL nest_first_mret got %h exp 0000", bus.irq_ret_o); end
    checks++; if (bus.irq_cause_o !== 32'h8000_0013) begin errors++; $display("FAIL nest_still_in got %h exp 80000013", bus.irq_cause_o); end
    do_mret();
    bus.irq_req_i = 16'h0;
    #1;
    checks++; if (bus.irq_ret_o !== 16'h0008) begin errors++; $display("FAIL nest_ack got %h exp 0008", bus.irq_ret_o); end
    tick();
    checks++; if (bus.irq_ret_o !== 16'h0) begin errors++; $display("FAIL nest_ack_pulse got %h exp 0000", bus.irq_ret_o); end
  endtask
  task automatic test_back_to_back();
    bus.irq_req_i = 16'h0021;
    #1;
    checks++; if (bus.irq_cause_o !== 32'h8000_0010) begin errors++; $display("FAIL b2b_first got %h exp 80000010", bus.irq_cause_o); end
    tick();
    do_mret();
    #1;
    checks++; if (bus.irq_ret_o !== 16'h0001) begin errors++; $display("FAIL b2b_ack got %h exp 0001", bus.irq_ret_o); end
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL b2b_ack_block got %b exp 0", bus.irq_o); end
    bus.irq_req_i = 16'h0020;
    tick();
    checks++; if (bus.irq_o !== 1'b1) begin errors++; $display("FAIL b2b_second_take got %b exp 1", bus.irq_o); end
    checks++; if (bus.irq_cause_o !== 32'h8000_0015) begin errors++; $display("FAIL b2b_second got %h exp 80000015", bus.irq_cause_o); end
    tick();
    do_mret();
    bus.irq_req_i = 16'h0;
    #1;
    checks++; if (bus.irq_ret_o !== 16'h0020) begin errors++; $display("FAIL b2b_ack2 got %h exp 0020", bus.irq_ret_o); end
    tick();
  endtask
  task automatic test_reset_mid();
    bus.irq_req_i = 16'h0002;
    tick();
    checks++; if (bus.irq_cause_o !== 32'h8000_0011) begin errors++; $display("FAIL rmid_service got %h exp 80000011", bus.irq_cause_o); end
    rst_i = 1'b1;
    #1;
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL rmid_irq got %b exp 0", bus.irq_o); end
    checks++; if (bus.irq_cause_o !== 32'h0) begin errors++; $display("FAIL rmid_cause got %h exp 0", bus.irq_cause_o); end
    bus.irq_req_i = 16'h0;
    tick();
    rst_i = 1'b0;
    bus.mret_i = 1'b1;
    tick();
    bus.mret_i = 1'b0;
    #1;
    checks++; if (bus.irq_ret_o !== 16'h0) begin errors++; $display("FAIL rmid_no_ack got %h exp 0000", bus.irq_ret_o); end
    checks++; if (bus.irq_cause_o !== 32'h0) begin errors++; $display("FAIL rmid_idle got %h exp 0", bus.irq_cause_o); end
    tick();
  endtask
  initial begin
    test_reset();
    test_priority();
    test_masking();
    test_block();
    test_nesting();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
